// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
//
// Shares a single Avalon-MM SDRAM agent port among NUM_HOSTS Avalon hosts.
// One host owns the agent at a time for a complete burst:
//   - Write bursts stay granted until the latched number of accepted write
//     beats has gone out.
//   - Read bursts stay granted until the command is accepted and every read
//     data beat has come back.
// After each burst the arbiter spends one IDLE cycle before it issues the
// next grant.
//
// Arbitration policy:
//   - Default build: fixed priority. The lowest requesting index wins, so
//     host 0 (the display port) has the highest priority.
//   - With SDRAM_ARB_ROUND_ROBIN_EN defined: round robin. The grant goes to
//     the first requester at or after a rotating pointer. The pointer then
//     moves to just past the granted host.
//
// Parameters:
//   NUM_HOSTS     number of host ports (2..8)
//   ADDR_W        Avalon address width
//   DATA_W        Avalon data width (byteenable is DATA_W/8)
//   BURSTCOUNT_W  burstcount width
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   h_read/h_write            per-host command strobes (bit i = host i)
//   h_address/h_writedata/
//   h_byteenable/h_burstcount per-host fields packed, host i in slice i
//   h_waitrequest             per-host stall; only the granted host can see 0
//   h_readdatavalid           per-host read data strobe
//   h_readdata                read data shared by all hosts
//   s_*                       Avalon-MM port toward the SDRAM agent
// ---------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int NUM_HOSTS    = 3,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int BURSTCOUNT_W = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_HOSTS-1:0]              h_read,
    input  logic [NUM_HOSTS-1:0]              h_write,
    input  logic [NUM_HOSTS*ADDR_W-1:0]       h_address,
    input  logic [NUM_HOSTS*DATA_W-1:0]       h_writedata,
    input  logic [NUM_HOSTS*(DATA_W/8)-1:0]   h_byteenable,
    input  logic [NUM_HOSTS*BURSTCOUNT_W-1:0] h_burstcount,
    output logic [NUM_HOSTS-1:0]              h_waitrequest,
    output logic [NUM_HOSTS-1:0]              h_readdatavalid,
    output logic [DATA_W-1:0]                 h_readdata,
    output logic                              s_read,
    output logic                              s_write,
    output logic [ADDR_W-1:0]                 s_address,
    output logic [DATA_W-1:0]                 s_writedata,
    output logic [DATA_W/8-1:0]               s_byteenable,
    output logic [BURSTCOUNT_W-1:0]           s_burstcount,
    input  logic                              s_waitrequest,
    input  logic                              s_readdatavalid,
    input  logic [DATA_W-1:0]                 s_readdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;
    localparam int CNT_W = BURSTCOUNT_W + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_CMD   = 2'd2,
        RD_WAIT  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  grant, grant_next;
    logic [CNT_W-1:0]  burst_len, burst_len_next;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_next;
    logic [NUM_HOSTS-1:0] req;
    logic [IDX_W-1:0]  pick;
    logic              pick_valid;
    logic [BURSTCOUNT_W-1:0] pick_bc;
    logic              beat_last;

    logic [ADDR_W-1:0]       addr_arr [NUM_HOSTS];
    logic [DATA_W-1:0]       wdata_arr[NUM_HOSTS];
    logic [BE_W-1:0]         be_arr   [NUM_HOSTS];
    logic [BURSTCOUNT_W-1:0] bc_arr   [NUM_HOSTS];

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]  rr_ptr, rr_ptr_next;
`endif

    // Unpack the flat per-host buses so the granted host's fields can be
    // selected with a plain array index.
    for (genvar i = 0; i < NUM_HOSTS; i++) begin : g_slice
        assign addr_arr[i]  = h_address[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = h_writedata[i*DATA_W +: DATA_W];
        assign be_arr[i]    = h_byteenable[i*BE_W +: BE_W];
        assign bc_arr[i]    = h_burstcount[i*BURSTCOUNT_W +: BURSTCOUNT_W];
    end

    assign req        = h_read | h_write;
    assign pick_bc    = bc_arr[pick];
    assign beat_last  = (beat_cnt + CNT_W'(1)) == burst_len;
    assign h_readdata = s_readdata;

    // Data and address always follow the latched grant. Whether the agent
    // acts on them is decided only by the s_read/s_write strobes below.
    assign s_address    = addr_arr[grant];
    assign s_writedata  = wdata_arr[grant];
    assign s_byteenable = be_arr[grant];
    assign s_burstcount = bc_arr[grant];

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    // Round-robin selection: walk the hosts starting at the pointer. The
    // first requester found wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        pick       = '0;
        pick_valid = 1'b0;
        cand       = '0;
        for (int k = 0; k < NUM_HOSTS; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_HOSTS);
            if (!pick_valid && req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end
`else
    // Fixed-priority selection: the scan runs from the top down, so the
    // lowest requesting index is the last one written and wins.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = NUM_HOSTS - 1; k >= 0; k--) begin
            if (req[k]) begin
                pick       = IDX_W'(k);
                pick_valid = 1'b1;
            end
        end
    end
`endif

    // State register. Reset takes effect immediately, which drops the
    // outputs back to their idle values in the same cycle and abandons any
    // burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            burst_len <= '0;
            beat_cnt  <= '0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            rr_ptr    <= '0;
`endif
        end else begin
            state     <= state_next;
            grant     <= grant_next;
            burst_len <= burst_len_next;
            beat_cnt  <= beat_cnt_next;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            rr_ptr    <= rr_ptr_next;
`endif
        end
    end

    // Outputs and next state.
    //
    // Only the strobe that matches the current burst type is forwarded.
    // This keeps a host that holds both h_read and h_write from issuing a
    // stray read during its write burst.
    //
    // Once a read command has been accepted (RD_WAIT), the host is held off
    // with waitrequest while the arbiter waits for its data.
    //
    // Read data valid pulses that arrive outside a read burst are dropped.
    always_comb begin
        s_read          = 1'b0;
        s_write         = 1'b0;
        h_waitrequest   = '1;
        h_readdatavalid = '0;
        state_next      = state;
        grant_next      = grant;
        burst_len_next  = burst_len;
        beat_cnt_next   = beat_cnt;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        rr_ptr_next     = rr_ptr;
`endif
        case (state)
            IDLE: begin
                beat_cnt_next = '0;
                if (pick_valid) begin
                    grant_next     = pick;
                    burst_len_next = (pick_bc == '0) ? CNT_W'(1) : {1'b0, pick_bc};
                    state_next     = h_write[pick] ? WR_BURST : RD_CMD;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
                    rr_ptr_next    = (int'(pick) == NUM_HOSTS - 1) ? '0 : pick + IDX_W'(1);
`endif
                end
            end
            WR_BURST: begin
                s_write              = h_write[grant];
                h_waitrequest[grant] = s_waitrequest;
                if (h_write[grant] && !s_waitrequest) begin
                    if (beat_last) begin
                        state_next    = IDLE;
                        beat_cnt_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt + CNT_W'(1);
                    end
                end
            end
            RD_CMD: begin
                s_read                 = h_read[grant];
                h_waitrequest[grant]   = s_waitrequest;
                h_readdatavalid[grant] = s_readdatavalid;
                if (h_read[grant] && !s_waitrequest) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                h_readdatavalid[grant] = s_readdatavalid;
                if (s_readdatavalid) begin
                    if (beat_last) begin
                        state_next    = IDLE;
                        beat_cnt_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbiter
//
// Directed testbench for sdram_arbiter, configured with three hosts.
//
// Checking is done two ways:
//   - A transaction-level model tracks which host owns the agent, what kind
//     of burst it is running, and how many beats remain. A compare process
//     checks every DUT output against this model on every falling edge.
//   - Each directed scenario also checks hand-computed literal results such
//     as beat counts, grant order and idle timing.
//
// Inputs change 1 time unit after the rising edge. Outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_sdram_arbiter;

    localparam int NH  = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = 6;
    localparam int BEW = DW / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NH-1:0]     h_read, h_write;
    logic [NH*AW-1:0]  h_address;
    logic [NH*DW-1:0]  h_writedata;
    logic [NH*BEW-1:0] h_byteenable;
    logic [NH*BW-1:0]  h_burstcount;
    logic [NH-1:0]     h_waitrequest, h_readdatavalid;
    logic [DW-1:0]     h_readdata;
    logic              s_read, s_write;
    logic [AW-1:0]     s_address;
    logic [DW-1:0]     s_writedata;
    logic [BEW-1:0]    s_byteenable;
    logic [BW-1:0]     s_burstcount;
    logic              s_waitrequest, s_readdatavalid;
    logic [DW-1:0]     s_readdata;

    int checks   = 0;
    int failures = 0;

    sdram_arbiter #(
        .NUM_HOSTS(NH), .ADDR_W(AW), .DATA_W(DW), .BURSTCOUNT_W(BW)
    ) dut (
        .clk(clk), .rst(rst),
        .h_read(h_read), .h_write(h_write),
        .h_address(h_address), .h_writedata(h_writedata),
        .h_byteenable(h_byteenable), .h_burstcount(h_burstcount),
        .h_waitrequest(h_waitrequest), .h_readdatavalid(h_readdatavalid),
        .h_readdata(h_readdata),
        .s_read(s_read), .s_write(s_write), .s_address(s_address),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_burstcount(s_burstcount), .s_waitrequest(s_waitrequest),
        .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata)
    );

    always #5 clk = ~clk;

    // One comparison: count it, and report it if it does not match.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive the command strobes, burst lengths and agent handshake together.
    task automatic applyStimulus(input logic [NH-1:0] rd, input logic [NH-1:0] wr,
                                 input logic [BW-1:0] bc0, input logic [BW-1:0] bc1,
                                 input logic [BW-1:0] bc2, input logic swait,
                                 input logic srdv);
        h_read          = rd;
        h_write         = wr;
        h_burstcount    = {bc2, bc1, bc0};
        s_waitrequest   = swait;
        s_readdatavalid = srdv;
    endtask

    // Hold reset for two rising edges, then release it with all inputs idle.
    task automatic doReset();
        rst = 1'b1;
        applyStimulus('0, '0, 6'd1, 6'd1, 6'd1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Each host has its own address base: host i uses 0x1000*(i+1).
    function automatic int hostOf(input logic [AW-1:0] a);
        return int'(a >> 12) - 1;
    endfunction

    // ------------------------------------------------------------------
    // Transaction-level reference model
    // ------------------------------------------------------------------
    logic m_busy = 1'b0;
    logic m_wr   = 1'b0;
    logic m_acc  = 1'b0;
    int   m_host = 0;
    int   m_rem  = 0;
    int   m_rr   = 0;

    function automatic int pickHost(input logic [NH-1:0] r, input int ptr);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < NH; k++) begin
            if (r[(ptr + k) % NH]) return (ptr + k) % NH;
        end
`else
        if (ptr < 0) return 0;
        for (int k = 0; k < NH; k++) begin
            if (r[k]) return k;
        end
`endif
        return 0;
    endfunction

    function automatic int burstOf(input int h);
        logic [BW-1:0] b;
        b = h_burstcount[h*BW +: BW];
        return (b == '0) ? 1 : int'(b);
    endfunction

    // Advance the model by one clock.
    //   - Idle: a waiting request becomes the owner.
    //   - Write burst: ends after the required number of accepted beats.
    //   - Read burst: first waits for its command to be accepted, then
    //     ends after the required number of data beats.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_wr   <= 1'b0;
            m_acc  <= 1'b0;
            m_host <= 0;
            m_rem  <= 0;
            m_rr   <= 0;
        end else if (!m_busy) begin
            if (|(h_read | h_write)) begin
                m_busy <= 1'b1;
                m_host <= pickHost(h_read | h_write, m_rr);
                m_wr   <= h_write[pickHost(h_read | h_write, m_rr)];
                m_rem  <= burstOf(pickHost(h_read | h_write, m_rr));
                m_acc  <= 1'b0;
                m_rr   <= (pickHost(h_read | h_write, m_rr) + 1) % NH;
            end
        end else if (m_wr) begin
            if (h_write[m_host] && !s_waitrequest) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) m_busy <= 1'b0;
            end
        end else if (!m_acc) begin
            if (h_read[m_host] && !s_waitrequest) m_acc <= 1'b1;
        end else if (s_readdatavalid) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) m_busy <= 1'b0;
        end
    end

    logic          exp_sw, exp_sr;
    logic [NH-1:0] exp_wait, exp_rdv;

    // Derive the expected outputs from the model state and current inputs.
    always_comb begin
        exp_sw   = m_busy && m_wr && h_write[m_host];
        exp_sr   = m_busy && !m_wr && !m_acc && h_read[m_host];
        exp_wait = '1;
        exp_rdv  = '0;
        if (m_busy && (m_wr || !m_acc)) exp_wait[m_host] = s_waitrequest;
        if (m_busy && !m_wr) exp_rdv[m_host] = s_readdatavalid;
    end

    // Check every output against the model on every falling edge.
    always @(negedge clk) begin
        checkOutput("s_write", 64'(s_write), 64'(exp_sw));
        checkOutput("s_read", 64'(s_read), 64'(exp_sr));
        checkOutput("h_waitrequest", 64'(h_waitrequest), 64'(exp_wait));
        checkOutput("h_readdatavalid", 64'(h_readdatavalid), 64'(exp_rdv));
        checkOutput("h_readdata", 64'(h_readdata), 64'(s_readdata));
        if (m_busy) begin
            checkOutput("s_address", 64'(s_address), 64'(h_address[m_host*AW +: AW]));
            checkOutput("s_writedata", 64'(s_writedata), 64'(h_writedata[m_host*DW +: DW]));
            checkOutput("s_byteenable", 64'(s_byteenable), 64'(h_byteenable[m_host*BEW +: BEW]));
            checkOutput("s_burstcount", 64'(s_burstcount), 64'(h_burstcount[m_host*BW +: BW]));
        end
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    int beats, first, bad, p0, pOther, rdCmds, n;
    int got[6];
    int expOrder[6];
    bit rdvPat[16] = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};

    initial begin
        h_address    = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        h_writedata  = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        h_byteenable = {4'hC, 4'h3, 4'hF};
        s_readdata   = '0;

        // Reset dominates active requests and stray read data.
        applyStimulus('0, 3'b111, 6'd1, 6'd1, 6'd1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("rst_wait", 64'(h_waitrequest), 64'h7);
        checkOutput("rst_swrite", 64'(s_write), 64'h0);
        checkOutput("rst_sread", 64'(s_read), 64'h0);
        checkOutput("rst_rdv", 64'(h_readdatavalid), 64'h0);
        @(posedge clk);
        #1;

        // Host 1 writes a burst of 4 with no backpressure.
        doReset();
        $display("[TB] host 1 write burst 4");
        applyStimulus('0, 3'b010, 6'd1, 6'd4, 6'd1, 1'b0, 1'b0);
        beats = 0; first = -1; bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (beats == 4) h_write = '0;
            @(negedge clk);
            if (s_write) begin
                beats++;
                if (first < 0) first = c;
            end
            if (h_waitrequest[0] !== 1'b1 || h_waitrequest[2] !== 1'b1) bad++;
            if (c == 5) checkOutput("t1_idle_wait", 64'(h_waitrequest), 64'h7);
            @(posedge clk);
            #1;
        end
        checkOutput("t1_first_beat", 64'(first), 64'd1);
        checkOutput("t1_beats", 64'(beats), 64'd4);
        checkOutput("t1_others_waiting", 64'(bad), 64'd0);

        // Host 0 reads a burst of 8; read data returns with gaps, and stray
        // valids arrive afterwards in IDLE.
        doReset();
        $display("[TB] host 0 read burst 8");
        applyStimulus(3'b001, '0, 6'd8, 6'd1, 6'd1, 1'b0, 1'b0);
        p0 = 0; pOther = 0; rdCmds = 0;
        for (int c = 0; c < 18; c++) begin
            if (c == 2) h_read = '0;
            if (c >= 2) s_readdatavalid = rdvPat[c-2];
            s_readdata = 32'hD000_0000 + 32'(c);
            @(negedge clk);
            if (s_read) rdCmds++;
            if (h_readdatavalid[0]) p0++;
            if (h_readdatavalid[2:1] != 2'b00) pOther++;
            if (c == 16) begin
                checkOutput("t2_idle_wait", 64'(h_waitrequest), 64'h7);
                checkOutput("t2_idle_rdv", 64'(h_readdatavalid), 64'h0);
            end
            @(posedge clk);
            #1;
        end
        s_readdatavalid = 1'b0;
        checkOutput("t2_rd_cmds", 64'(rdCmds), 64'd1);
        checkOutput("t2_host0_valids", 64'(p0), 64'd8);
        checkOutput("t2_other_valids", 64'(pOther), 64'd0);

        // All hosts request continuously with burst 1; check grant order.
        doReset();
        $display("[TB] grant order with three continuous requesters");
        applyStimulus('0, 3'b111, 6'd1, 6'd1, 6'd1, 1'b0, 1'b0);
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (s_write && n < 6) begin
                got[n] = hostOf(s_address);
                n++;
            end
            @(posedge clk);
            #1;
        end
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        expOrder = '{0, 1, 2, 0, 1, 2};
`else
        expOrder = '{0, 0, 0, 0, 0, 0};
`endif
        checkOutput("t3_grant_count", 64'(n), 64'd6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("t3_grant%0d", i), 64'(got[i]), 64'(expOrder[i]));
        end

        // Reset in the middle of beat 2 of a burst-4 write.
        doReset();
        $display("[TB] reset during write burst");
        applyStimulus('0, 3'b010, 6'd1, 6'd4, 6'd1, 1'b0, 1'b0);
        beats = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (s_write) beats++;
            if (c < 2) begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput("t4_beats_before_rst", 64'(beats), 64'd2);
        #2 rst = 1'b1;
        #1;
        checkOutput("t4_swrite_in_rst", 64'(s_write), 64'h0);
        checkOutput("t4_wait_in_rst", 64'(h_waitrequest), 64'h7);
        @(posedge clk);
        #1 rst = 1'b0;
        beats = 0; first = -1;
        for (int c = 0; c < 8; c++) begin
            if (beats == 4) h_write = '0;
            @(negedge clk);
            if (s_write) begin
                beats++;
                if (first < 0) first = c;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("t4_first_after_rst", 64'(first), 64'd1);
        checkOutput("t4_beats_after_rst", 64'(beats), 64'd4);

        // A burstcount of 0 on a read behaves as a single beat.
        doReset();
        $display("[TB] host 2 read burstcount 0");
        applyStimulus(3'b100, '0, 6'd1, 6'd1, 6'd0, 1'b0, 1'b0);
        rdCmds = 0; p0 = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) h_read = '0;
            s_readdatavalid = (c == 3 || c == 4);
            @(negedge clk);
            if (s_read) rdCmds++;
            if (h_readdatavalid[2]) p0++;
            if (c == 4) begin
                checkOutput("t5_idle_wait", 64'(h_waitrequest), 64'h7);
                checkOutput("t5_idle_rdv", 64'(h_readdatavalid), 64'h0);
            end
            @(posedge clk);
            #1;
        end
        checkOutput("t5_rd_cmds", 64'(rdCmds), 64'd1);
        checkOutput("t5_valids", 64'(p0), 64'd1);

        // Mixed traffic with backpressure, stray read data and a mid-burst
        // command drop; checked against the model only.
        doReset();
        $display("[TB] mixed traffic with backpressure");
        applyStimulus(3'b010, 3'b001, 6'd3, 6'd2, 6'd1, 1'b0, 1'b0);
        for (int c = 0; c < 30; c++) begin
            s_waitrequest   = (c % 3 == 1);
            s_readdatavalid = (c % 2 == 0);
            s_readdata      = 32'hB000_0000 + 32'(c);
            h_write[0]      = !(c == 3 || c == 4);
            @(negedge clk);
            @(posedge clk);
            #1;
        end

        doReset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net: end the run with a failure if the directed sequence stalls.
    initial begin
        #100000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter NUM_HOSTS, default 3, number of Avalon host ports arbitrated (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, Avalon address width.
REQ-003 SHALL have parameter DATA_W, default 32, Avalon data width; byteenable width is DATA_W/8.
REQ-004 SHALL have parameter BURSTCOUNT_W, default 6, burstcount width.
REQ-005 SHALL have ports clk (input, 1, sole clock) and rst (input, 1, reset); one clock, reset asynchronous and active-high.
REQ-006 SHALL have h_read, h_write (input, NUM_HOSTS, per-host command strobes, bit i = host i).
REQ-007 SHALL have h_address (input, NUM_HOSTS*ADDR_W), h_writedata (input, NUM_HOSTS*DATA_W), h_byteenable (input, NUM_HOSTS*DATA_W/8), h_burstcount (input, NUM_HOSTS*BURSTCOUNT_W), host i in slice i.
REQ-008 SHALL have h_waitrequest, h_readdatavalid (output, NUM_HOSTS) and h_readdata (output, DATA_W, shared by all hosts).
REQ-009 SHALL have s_read, s_write, s_address, s_writedata, s_byteenable, s_burstcount (outputs, single-port widths) and s_waitrequest, s_readdatavalid, s_readdata (inputs) toward the SDRAM agent.

Function
REQ-010 SHALL implement FSM states IDLE, WR_BURST, RD_CMD, RD_WAIT.
REQ-011 In IDLE, SHALL forward nothing (s_read = s_write = 0) and hold all h_waitrequest high.
REQ-012 In IDLE, with any req(i) = h_read(i)|h_write(i) set, SHALL latch grant index g and that host's burstcount and enter WR_BURST (h_write(g)) or RD_CMD (h_read(g)) on the next edge; h_write takes precedence if both are set.
REQ-013 Grant index SHALL be selected per REQ-030.
REQ-014 In any non-IDLE state, SHALL mux host g's command signals to s_*; h_waitrequest(g) = s_waitrequest; all other h_waitrequest = 1.
REQ-015 WR_BURST SHALL count beats where s_write && !s_waitrequest; on the beat that reaches the latched burstcount, SHALL return to IDLE.
REQ-016 RD_CMD SHALL move to RD_WAIT on the cycle s_read && !s_waitrequest; from RD_WAIT onward s_read SHALL be 0 and h_waitrequest(g) SHALL be 1.
REQ-017 RD_WAIT SHALL count s_readdatavalid beats and return to IDLE on the beat reaching the latched burstcount.
REQ-018 h_readdata SHALL equal s_readdata combinationally; h_readdatavalid(g) = s_readdatavalid during RD_CMD/RD_WAIT; all other bits 0.
REQ-019 A latched burstcount of 0 SHALL be treated as 1.
REQ-020 Beat counters SHALL be BURSTCOUNT_W+1 bits and SHALL clear on every entry to IDLE.
REQ-021 A new request arriving during a burst SHALL wait; on burst completion the FSM SHALL pass through one IDLE cycle before the next grant (grant latency 1 cycle from IDLE).
REQ-022 A granted host deasserting its command mid-burst SHALL NOT cause a state change; the arbiter waits for the remaining beats.
REQ-023 s_readdatavalid received in IDLE or WR_BURST SHALL be ignored and not routed to any host.

Reset
REQ-024 While rst is high, FSM SHALL be IDLE, g = 0, counters = 0, round-robin pointer = 0.
REQ-025 Reset values: s_read = s_write = 0, all h_waitrequest = 1, all h_readdatavalid = 0.
REQ-026 Reset asserted mid-burst SHALL abort the burst immediately, with no residual beats forwarded after release.

Configuration
REQ-030 With macro SDRAM_ARB_ROUND_ROBIN_EN defined, SHALL grant the first requesting index at or after pointer p (wrapping), and set p = g+1 mod NUM_HOSTS at grant; without it, SHALL grant the lowest requesting index (host 0 highest priority, the display port), with no pointer register.

Verification
REQ-031 Host 1 writes burst 4, s_waitrequest low -> grant 1 cycle after request, 4 s_write beats, IDLE after 4th beat, h_waitrequest(0,2) high throughout.
REQ-032 Host 0 reads burst 8, SDRAM returns 8 valids with gaps -> h_readdatavalid(0) pulses exactly 8 times, other hosts 0, IDLE after 8th.
REQ-033 Hosts 0,1,2 request continuously with burst 1, RR enabled -> grant order 0,1,2,0,1,2; RR disabled -> host 0 always granted.
REQ-034 rst asserted at beat 2 of a burst-4 write -> s_write 0 and FSM IDLE the same cycle; no beats forwarded after release.
REQ-035 Burstcount 0 read -> one command, one readdatavalid, then IDLE.
